// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath blocks.
//   COEFW_MAX / XW_MAX / OUTW_MAX : DSP48 operand and accumulator limits
//   fir_state_e                    : coefficient loader state encoding
//   clog2                          : constant-safe ceil(log2(n)) helper
package fir_pkg;

  localparam int unsigned COEFW_MAX = 18;
  localparam int unsigned XW_MAX    = 25;
  localparam int unsigned OUTW_MAX  = 48;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFill   = 2'd1,
    StDrain  = 2'd2,
    StCommit = 2'd3
  } fir_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/fir_coef_loader_if.sv
// Coefficient stream (valid/ready with end-of-set marker).
//   s_coef_data  : coefficient word, first word of a set is tap 0
//   s_coef_valid : word valid
//   s_coef_last  : final word of a set
//   s_coef_ready : sink can accept a word
// master = stream source (control/DMA), slave = coefficient loader.
interface fir_coef_loader_if #(
  parameter int unsigned COEFW = 18
) ();

  logic [COEFW-1:0] s_coef_data;
  logic             s_coef_valid;
  logic             s_coef_last;
  logic             s_coef_ready;

  modport master (
    output s_coef_data,
    output s_coef_valid,
    output s_coef_last,
    input  s_coef_ready
  );

  modport slave (
    input  s_coef_data,
    input  s_coef_valid,
    input  s_coef_last,
    output s_coef_ready
  );

endinterface

// File: rtl/fir_coef_loader.sv
// Double-buffered FIR coefficient loader.
// Words of a set fill a shadow bank; only a complete set of exactly NTAPS words
// terminated by last is copied to the active bank, so the taps never see a partial set.
//   clk       : system clock, rising edge
//   aresetn   : asynchronous active-low reset
//   s_coef    : coefficient stream (slave modport)
//   coef_out  : active bank, tap i on [i*COEFW +: COEFW]
//   coef_swap : one-cycle pulse in the first cycle a new active bank is visible
//   load_busy : a set is partially received (FILL or DRAIN)
//   load_err  : sticky framing error, cleared by the next successful commit
// NTAPS must be at least 2.
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS = 16,
  parameter int unsigned COEFW = 18,
  parameter int unsigned IDXW  = clog2(NTAPS)
) (
  input  logic                   clk,
  input  logic                   aresetn,
  fir_coef_loader_if.slave       s_coef,
  output logic [NTAPS*COEFW-1:0] coef_out,
  output logic                   coef_swap,
  output logic                   load_busy,
  output logic                   load_err
);

  fir_state_e       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             err_q, err_d;
  logic             swap_q, swap_d;
  logic             accept;
  logic             shadow_we;
  logic             commit;
  logic [IDXW-1:0]  wr_idx;
  logic [COEFW-1:0] shadow_q [NTAPS];
  logic [COEFW-1:0] active_q [NTAPS];

  // Ready depends on state only, never on valid.
  assign s_coef.s_coef_ready = (state_q != StCommit);
  assign accept              = s_coef.s_coef_valid && s_coef.s_coef_ready;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    err_d     = err_q;
    swap_d    = 1'b0;
    shadow_we = 1'b0;
    commit    = 1'b0;
    wr_idx    = idx_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          shadow_we = 1'b1;
          wr_idx    = '0;
          if (s_coef.s_coef_last) begin
            // A one-word set can never be complete.
            err_d = 1'b1;
            idx_d = '0;
          end else begin
            idx_d   = IDXW'(1);
            state_d = StFill;
          end
        end
      end
      StFill: begin
        if (accept) begin
          shadow_we = 1'b1;
          if (idx_q == IDXW'(NTAPS - 1)) begin
            idx_d = '0;
            if (s_coef.s_coef_last) begin
              state_d = StCommit;
            end else begin
              err_d   = 1'b1;
              state_d = StDrain;
            end
          end else if (s_coef.s_coef_last) begin
            err_d   = 1'b1;
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IDXW'(1);
          end
        end
      end
      StDrain: begin
        if (accept && s_coef.s_coef_last) begin
          idx_d   = '0;
          state_d = StIdle;
        end
      end
      StCommit: begin
        commit  = 1'b1;
        swap_d  = 1'b1;
        err_d   = 1'b0;
        idx_d   = '0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= StIdle;
      idx_q   <= '0;
      err_q   <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      swap_q  <= swap_d;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < int'(NTAPS); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      if (shadow_we) shadow_q[wr_idx] <= s_coef.s_coef_data;
      if (commit) active_q <= shadow_q;
    end
  end

  for (genvar i = 0; i < int'(NTAPS); i++) begin : g_lane
    assign coef_out[i*COEFW +: COEFW] = active_q[i];
  end

  assign coef_swap = swap_q;
  assign load_busy = (state_q == StFill) || (state_q == StDrain);
  assign load_err  = err_q;

endmodule
